// File: rtl/draw_pkg.sv
// draw_pkg: shared types and constants for the drawing-engine sequencer.
//   - seq_state_t : sequencer FSM states
//   - pix_t       : one VGA adapter pixel (x, y, colour)
//   - VGA_*W      : adapter field widths
//   - ENG_*       : conventional slot assignment of the drawing engines
// No ports; imported by draw_sequencer and pixel_mux_reg.
package draw_pkg;

  localparam int VGA_XW = 8;
  localparam int VGA_YW = 7;
  localparam int VGA_CW = 3;

  // Slot order is run order: the screen is cleared before shapes are drawn.
  localparam int ENG_FILL     = 0;
  localparam int ENG_CIRCLE   = 1;
  localparam int ENG_REULEAUX = 2;

  localparam int PLOT_CNT_W = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_RUN,
    ST_RELEASE,
    ST_FINISH
  } seq_state_t;

  typedef struct packed {
    logic [VGA_XW-1:0] x;
    logic [VGA_YW-1:0] y;
    logic [VGA_CW-1:0] colour;
  } pix_t;

endpackage

// File: rtl/pixel_mux_reg.sv
// pixel_mux_reg: registered NUM_ENG:1 pixel mux feeding the VGA adapter.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_sel          slot whose pixel stream is forwarded
//   i_run_valid    high while the selected slot owns the adapter port
//   i_pix, i_plot  per-slot pixel and plot strobe
//   o_pix, o_plot  registered pixel and gated plot (1 clk latency)
// The pixel fields only load while i_run_valid is high, so the adapter sees
// the last drawn pixel held between runs; only the plot strobe is gated.
module pixel_mux_reg
  import draw_pkg::*;
#(
  parameter int NUM_ENG = 3,
  parameter int IDX_W   = $clog2(NUM_ENG)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [IDX_W-1:0]        i_sel,
  input  logic                    i_run_valid,
  input  pix_t [NUM_ENG-1:0]      i_pix,
  input  logic [NUM_ENG-1:0]      i_plot,
  output pix_t                    o_pix,
  output logic                    o_plot
);

  localparam int STAGES = 1;

  pix_t              w_pix;
  logic              w_plot;
  logic              w_vld_in;
  logic [STAGES:1]   r_vld_pipe;
  pix_t              r_pix;

  // Compare-based select keeps unused index codes (non power-of-two
  // NUM_ENG) harmless: they select nothing and never plot.
  always_comb begin
    w_pix  = '0;
    w_plot = 1'b0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (i_sel == IDX_W'(i)) begin
        w_pix  = i_pix[i];
        w_plot = i_plot[i];
      end
    end
  end

  assign w_vld_in = i_run_valid & w_plot;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pix      <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= w_vld_in;
      for (int s = 2; s <= STAGES; s++) r_vld_pipe[s] <= r_vld_pipe[s-1];
      if (i_run_valid) r_pix <= w_pix;
    end
  end

  assign o_pix  = r_pix;
  assign o_plot = r_vld_pipe[STAGES];

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: runs the enabled drawing engines one at a time in slot
// order and shares the single VGA adapter pixel port between them.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start / o_done    level request / completion handshake with the host
//   i_engine_en         per-slot enable, captured when a run is accepted
//   o_busy              high from run acceptance until done
//   o_active_idx        slot currently granted
//   o_eng_start         one-hot level start to each engine
//   i_eng_done          per-engine done
//   i_eng_x/y/colour    packed per-slot pixel, slot i at [W*i +: W]
//   i_eng_plot          per-slot plot strobe
//   o_vga_*             registered pixel port to vga_adapter
//   o_plot_count        (PLOT_COUNT_EN only) saturating count of plots in
//                       the current/last run
// Optional feature macro: PLOT_COUNT_EN.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int NUM_ENG = 3,
  parameter int IDX_W   = $clog2(NUM_ENG)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [NUM_ENG-1:0]          i_engine_en,
  output logic                        o_done,
  output logic                        o_busy,
  output logic [IDX_W-1:0]            o_active_idx,
  output logic [NUM_ENG-1:0]          o_eng_start,
  input  logic [NUM_ENG-1:0]          i_eng_done,
  input  logic [NUM_ENG*VGA_XW-1:0]   i_eng_x,
  input  logic [NUM_ENG*VGA_YW-1:0]   i_eng_y,
  input  logic [NUM_ENG*VGA_CW-1:0]   i_eng_colour,
  input  logic [NUM_ENG-1:0]          i_eng_plot,
  output logic [VGA_XW-1:0]           o_vga_x,
  output logic [VGA_YW-1:0]           o_vga_y,
  output logic [VGA_CW-1:0]           o_vga_colour,
  output logic                        o_vga_plot
`ifdef PLOT_COUNT_EN
  ,
  output logic [PLOT_CNT_W-1:0]       o_plot_count
`endif
);

  // Base needs one extra bit so "past the last slot" is representable.
  localparam int BW = IDX_W + 1;

  seq_state_t           r_state;
  logic [NUM_ENG-1:0]   r_mask;
  logic [BW-1:0]        r_base;
  logic [IDX_W-1:0]     r_active_idx;
  logic [NUM_ENG-1:0]   r_eng_start;
  logic                 r_done;
  logic                 r_busy;

  logic                 w_found;
  logic [IDX_W-1:0]     w_pick_idx;
  logic [NUM_ENG-1:0]   w_onehot;
  logic                 w_act_done;
  logic                 w_run_valid;
  pix_t [NUM_ENG-1:0]   w_pix;
  pix_t                 w_mux_pix;
  logic                 w_mux_plot;

  // Unpack the flat per-slot buses into pixel structs.
  for (genvar g = 0; g < NUM_ENG; g++) begin : g_unpack
    assign w_pix[g] = {i_eng_x[g*VGA_XW +: VGA_XW],
                       i_eng_y[g*VGA_YW +: VGA_YW],
                       i_eng_colour[g*VGA_CW +: VGA_CW]};
  end

  // Lowest set mask bit at or above base; scanning downward lets the last
  // hit (lowest index) win.
  always_comb begin
    w_found    = 1'b0;
    w_pick_idx = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (r_mask[i] && (BW'(i) >= r_base)) begin
        w_found    = 1'b1;
        w_pick_idx = IDX_W'(i);
      end
    end
  end

  assign w_onehot = {{(NUM_ENG-1){1'b0}}, 1'b1} << w_pick_idx;

  always_comb begin
    w_act_done = 1'b0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (r_active_idx == IDX_W'(i)) w_act_done = i_eng_done[i];
    end
  end

  // Gating with i_start means a plot coinciding with an abort is dropped.
  assign w_run_valid = (r_state == ST_RUN) && i_start;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_mask       <= '0;
      r_base       <= '0;
      r_active_idx <= '0;
      r_eng_start  <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_mask  <= i_engine_en;
            r_busy  <= 1'b1;
            r_base  <= '0;
            r_state <= ST_PICK;
          end
        end
        ST_PICK: begin
          if (!i_start) begin
            r_eng_start <= '0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (w_found) begin
            r_active_idx <= w_pick_idx;
            r_eng_start  <= w_onehot;
            r_state      <= ST_RUN;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_FINISH;
          end
        end
        ST_RUN: begin
          if (!i_start) begin
            r_eng_start <= '0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (w_act_done) begin
            r_eng_start <= '0;
            r_state     <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // Wait for the engine to drop done so a stale done can never be
          // mistaken for completion of its next run.
          if (!i_start) begin
            r_eng_start <= '0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (!w_act_done) begin
            r_base  <= {1'b0, r_active_idx} + BW'(1);
            r_state <= ST_PICK;
          end
        end
        ST_FINISH: begin
          if (!i_start) begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_eng_start <= '0;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  pixel_mux_reg #(
    .NUM_ENG (NUM_ENG),
    .IDX_W   (IDX_W)
  ) u_pix_mux (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sel       (r_active_idx),
    .i_run_valid (w_run_valid),
    .i_pix       (w_pix),
    .i_plot      (i_eng_plot),
    .o_pix       (w_mux_pix),
    .o_plot      (w_mux_plot)
  );

  assign o_done       = r_done;
  assign o_busy       = r_busy;
  assign o_active_idx = r_active_idx;
  assign o_eng_start  = r_eng_start;
  assign o_vga_x      = w_mux_pix.x;
  assign o_vga_y      = w_mux_pix.y;
  assign o_vga_colour = w_mux_pix.colour;
  assign o_vga_plot   = w_mux_plot;

`ifdef PLOT_COUNT_EN
  logic [PLOT_CNT_W-1:0] r_plot_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_plot_count <= '0;
    end else if (r_state == ST_IDLE && i_start) begin
      r_plot_count <= '0;
    end else if (w_mux_plot && !(&r_plot_count)) begin
      r_plot_count <= r_plot_count + 1'b1;
    end
  end

  assign o_plot_count = r_plot_count;
`endif

  a_eng_start_onehot0: assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0(r_eng_start));

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: scoreboard bench for draw_sequencer. Behavioural engine
// models plot five pixels after their start rises, then raise done until
// start drops (optionally holding it stale). Each forwarded-pixel
// expectation is queued when a started engine plots; a negedge monitor pops
// and compares whenever vga_plot is high.
module tb_draw_sequencer;
  import draw_pkg::*;

  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [N-1:0]   engine_en = '0;
  logic           done, busy;
  logic [1:0]     active_idx;
  logic [N-1:0]   eng_start;
  logic [N-1:0]   eng_done = '0;
  logic [N*8-1:0] eng_x = '0;
  logic [N*7-1:0] eng_y = '0;
  logic [N*3-1:0] eng_col = '0;
  logic [N-1:0]   eng_plot = '0;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_col;
  logic           vga_plot;
`ifdef PLOT_COUNT_EN
  logic [16:0]    plot_count;
`endif

  draw_sequencer #(.NUM_ENG(N)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_engine_en  (engine_en),
    .o_done       (done),
    .o_busy       (busy),
    .o_active_idx (active_idx),
    .o_eng_start  (eng_start),
    .i_eng_done   (eng_done),
    .i_eng_x      (eng_x),
    .i_eng_y      (eng_y),
    .i_eng_colour (eng_col),
    .i_eng_plot   (eng_plot),
    .o_vga_x      (vga_x),
    .o_vga_y      (vga_y),
    .o_vga_colour (vga_col),
    .o_vga_plot   (vga_plot)
`ifdef PLOT_COUNT_EN
    ,
    .o_plot_count (plot_count)
`endif
  );

  always #10 clk = ~clk;

  typedef struct {
    int         t;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] slog[$];
  int n_checks = 0, n_errors = 0, cyc = 0, n_plots = 0;
  int fall0_cyc = 0, rise1_cyc = 0;
  int phase[N], k[N], hold[N], stale[N];
  bit freerun[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Engine models: react 2ns after each edge, after the main process drives.
  initial begin
    logic       s;
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
    for (int i = 0; i < N; i++) begin
      phase[i] = 0; k[i] = 0; hold[i] = 0; stale[i] = 0; freerun[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        s = eng_start[i];
        eng_plot[i] = 1'b0;
        if (phase[i] == 0 && s) begin
          phase[i] = 1;
          k[i] = 0;
        end
        if (phase[i] == 1) begin
          if (!s) begin
            phase[i] = 0;
          end else if (k[i] < 5) begin
            px = 8'(16 * (i + 1) + k[i]);
            py = 7'(32 + 4 * i + k[i]);
            pc = 3'(i + 1);
            eng_plot[i] = 1'b1;
            eng_x[8*i +: 8] = px;
            eng_y[7*i +: 7] = py;
            eng_col[3*i +: 3] = pc;
            if (start && !rst) exp_q.push_back('{t: cyc, x: px, y: py, c: pc});
            k[i]++;
          end else begin
            eng_done[i] = 1'b1;
            phase[i] = 2;
            hold[i] = 0;
          end
        end else if (phase[i] == 2) begin
          if (!s) begin
            if (hold[i] >= stale[i]) begin
              eng_done[i] = 1'b0;
              phase[i] = 0;
            end else begin
              hold[i]++;
            end
          end
        end else if (freerun[i] && !s) begin
          eng_plot[i] = 1'b1;
          eng_x[8*i +: 8] = 8'hEE;
          eng_y[7*i +: 7] = 7'h55;
          eng_col[3*i +: 3] = 3'h7;
        end
      end
    end
  end

  // Monitor: eng_start history and pixel scoreboard.
  initial begin
    exp_t e;
    logic [N-1:0] prev_es;
    prev_es = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_es = '0;
      end else begin
        if (eng_start !== prev_es) begin
          chk("eng_start_onehot0", 32'($onehot0(eng_start)), 32'd1);
          if (eng_start != '0) slog.push_back(eng_start);
          if (prev_es[0] && !eng_start[0]) fall0_cyc = cyc;
          if (!prev_es[1] && eng_start[1]) rise1_cyc = cyc;
          prev_es = eng_start;
        end
        if (vga_plot) begin
          n_plots++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_plot: got pixel x=0x%0h y=0x%0h c=0x%0h, expected no plot",
                     vga_x, vga_y, vga_col);
          end else begin
            e = exp_q.pop_front();
            chk("pix_latency", cyc, e.t + 1);
            chk("pix_value", {vga_x, vga_y, vga_col}, {e.x, e.y, e.c});
          end
        end
      end
    end
  end

  task automatic wait_done(input string name);
    int t = 0;
    while (done !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(name, done, 1);
  endtask

  task automatic wait_es(input string name, input logic [N-1:0] v);
    int t = 0;
    while (eng_start !== v && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(name, eng_start, v);
  endtask

  task automatic new_run(input logic [N-1:0] en);
    slog.delete();
    n_plots = 0;
    @(posedge clk);
    #1;
    engine_en = en;
    start = 1'b1;
  endtask

  task automatic end_run(input string name);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({name, "_done_clear"}, done, 0);
    chk({name, "_busy_idle"}, busy, 0);
  endtask

  task automatic chk_log(input string name, input int n, input logic [2:0] a,
                         input logic [2:0] b, input logic [2:0] c);
    logic [2:0] ex[3];
    ex[0] = a; ex[1] = b; ex[2] = c;
    chk({name, "_log_len"}, slog.size(), n);
    for (int i = 0; i < n && i < slog.size(); i++) chk({name, "_log"}, slog[i], ex[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected sequence to complete");
    $fatal(1);
  end

  initial begin
    // Reset values
    #25;
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active_idx", active_idx, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_vga_plot", vga_plot, 0);
    chk("rst_vga_pix", {vga_x, vga_y, vga_col}, 0);
`ifdef PLOT_COUNT_EN
    chk("rst_plot_count", plot_count, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All enabled; enable changes mid-run must be ignored.
    new_run(3'b111);
    @(posedge clk);
    @(negedge clk);
    chk("t1_busy", busy, 1);
    wait_es("t1_first_start", 3'b001);
    engine_en = 3'b000;
    wait_done("t1_done");
    chk("t1_busy_clear", busy, 0);
    chk("t1_plots", n_plots, 15);
    chk("t1_queue_empty", exp_q.size(), 0);
    chk_log("t1", 3, 3'b001, 3'b010, 3'b100);
`ifdef PLOT_COUNT_EN
    chk("t1_plot_count", plot_count, 15);
`endif
    end_run("t1");

    // Skip slot 1; its free-running plots must never reach the adapter.
    freerun[1] = 1'b1;
    new_run(3'b101);
    wait_done("t2_done");
    chk("t2_plots", n_plots, 10);
    chk_log("t2", 2, 3'b001, 3'b100, 3'b000);
    end_run("t2");
    freerun[1] = 1'b0;

    // Empty mask: done two cycles after start, no plots, no starts.
    new_run(3'b000);
    @(posedge clk);
    @(negedge clk);
    chk("t3_done_early", done, 0);
    chk("t3_busy", busy, 1);
    @(posedge clk);
    @(negedge clk);
    chk("t3_done", done, 1);
    chk("t3_busy_clear", busy, 0);
    chk("t3_plots", n_plots, 0);
    chk("t3_log_len", slog.size(), 0);
    end_run("t3");

    // Stale done on slot 0 holds RELEASE for 3 extra cycles.
    stale[0] = 3;
    new_run(3'b011);
    wait_done("t4_done");
    chk("t4_release_gap", rise1_cyc - fall0_cyc, 5);
    chk("t4_plots", n_plots, 10);
    chk_log("t4", 2, 3'b001, 3'b010, 3'b000);
    end_run("t4");
    stale[0] = 0;

    // Abort mid-run on slot 1, then restart from slot 0.
    new_run(3'b111);
    wait_es("t5_slot1", 3'b010);
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5_abort_eng_start", eng_start, 0);
    chk("t5_abort_plot", vga_plot, 0);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_done", done, 0);
    repeat (4) @(negedge clk);
    chk("t5_done_stays_low", done, 0);
    chk("t5_queue_empty", exp_q.size(), 0);
    new_run(3'b111);
    wait_done("t5_restart_done");
    chk("t5_plots", n_plots, 15);
    chk_log("t5", 3, 3'b001, 3'b010, 3'b100);
    end_run("t5");

    // Asynchronous reset mid-run.
    new_run(3'b111);
    wait_es("t6_slot0", 3'b001);
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("t6_pre_reset_plot", vga_plot, 1);
    rst = 1'b1;
    start = 1'b0;
    #1;
    chk("t6_rst_eng_start", eng_start, 0);
    chk("t6_rst_plot", vga_plot, 0);
    chk("t6_rst_pix", {vga_x, vga_y, vga_col}, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_active_idx", active_idx, 0);
    exp_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    new_run(3'b111);
    wait_done("t6_done");
    chk("t6_plots", n_plots, 15);
    chk_log("t6", 3, 3'b001, 3'b010, 3'b100);
    end_run("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
Schedules the drawing engines (fillscreen, circle, Reuleaux triangle) and shares the single VGA adapter pixel port between them. It starts enabled engines one at a time, in fixed index order, using the level start/done handshake. It registers the active engine's pixel stream onto the adapter port. It sits between the engine instances and vga_adapter in each task top level, replacing the ad-hoc done-driven output muxes.

Parameters:
NUM_ENG, 3, number of engine slots; index 0 runs first (fillscreen by convention).
IDX_W, $clog2(NUM_ENG), width of the active index.

Ports:
clk  in  1  system clock (CLOCK_50).
rst  in  1  asynchronous, active-high reset.
start  in  1  level request; held high until done is seen.
engine_en  in  NUM_ENG  per-slot enable mask; latched when a run begins.
done  out  1  whole sequence complete; held until start drops.
busy  out  1  high from run acceptance until done.
active_idx  out  IDX_W  slot currently granted.
eng_start  out  NUM_ENG  one-hot level start to each engine.
eng_done  in  NUM_ENG  per-engine done.
eng_x  in  NUM_ENG*8  packed x, with slot i at [8i+7:8i].
eng_y  in  NUM_ENG*7  packed y.
eng_colour  in  NUM_ENG*3  packed colour.
eng_plot  in  NUM_ENG  per-engine plot strobe.
vga_x  out  8  to adapter.
vga_y  out  7  to adapter.
vga_colour  out  3  to adapter.
vga_plot  out  1  to adapter.

Behaviour:
- Reset (async, any state): state=IDLE. done, busy, eng_start, vga_plot, vga_x, vga_y, vga_colour, active_idx and mask all go to 0.
- States: IDLE, PICK, RUN, RELEASE, FINISH.
- IDLE: on start=1, latch engine_en into mask, set busy=1, go to PICK with search base 0.
- PICK (1 cycle): find the lowest set mask bit at index >= base.
  - If found: active_idx=that index, go to RUN.
  - If none: go to FINISH.
- RUN: eng_start[active_idx]=1; all other eng_start bits are 0.
  - Each cycle, vga_x/y/colour/plot register the active slot's inputs. Pixel latency is exactly 1 clk.
  - When eng_done[active_idx]=1, drop eng_start the next cycle and go to RELEASE. A done asserted in the first RUN cycle is honoured.
- RELEASE: eng_start all 0. Stay until eng_done[active_idx]=0, minimum 1 cycle. Then go to PICK with base=active_idx+1.
- FINISH: done=1, busy=0. Hold until start=0, then go to IDLE with done=0 in that same cycle.
- vga_plot is registered 0 in every state except RUN. Plots arriving in the RELEASE cycle are dropped. Inactive engines' eng_plot is always ignored.
- vga_x/y/colour hold their last value when not in RUN; only vga_plot is gated.
- Abort: if start drops in PICK, RUN or RELEASE:
  - eng_start goes to 0 the next cycle.
  - vga_plot goes to 0.
  - state goes to IDLE.
  - done is never asserted.
- engine_en changes during a run have no effect until the next run.
- mask=0: IDLE→PICK→FINISH, so done rises 2 cycles after start, with no plots.
- Base wrap: when active_idx=NUM_ENG-1, PICK goes directly to FINISH. No wrap-around to slot 0.
- Exactly one eng_start bit is ever high (one-hot or zero); verify this with an assertion.

Optional Feature:
PLOT_COUNT_EN: when defined, adds output plot_count [16:0].
- Cleared on rst and on each run acceptance in IDLE.
- Increments once per cycle in which vga_plot=1; saturates at all-ones.
- Holds through FINISH and IDLE for readout.
When undefined, the port and counter are absent, with no other behavioural change.

Decomposition:
- Package draw_pkg holds:
  - the state enum typedef;
  - constants VGA_XW=8, VGA_YW=7, VGA_CW=3;
  - localparams for the slot indices ENG_FILL=0, ENG_CIRCLE=1, ENG_REULEAUX=2.
- One sub-module, pixel_mux_reg: the registered NUM_ENG:1 pixel mux with the plot gate, selected by active_idx and a run_valid input.
- The FSM and priority search stay in draw_sequencer.

Test Plan:
- All enabled: mask=3'b111, bfm engines each assert done after 5 plots → eng_start pulses are 001, then 010, then 100. There are exactly 15 vga_plot cycles, each 1 clk after its engine's plot. done rises; with PLOT_COUNT_EN, plot_count=15.
- Skip: mask=3'b101 → slot 1 is never started; the sequence is 0 then 2; the circle engine's plots during the run are never forwarded.
- Empty mask: mask=0, start=1 → done=1 two cycles later, vga_plot stays 0, eng_start stays 0. Drop start → done=0 the next cycle.
- Stale done: engine 0 holds done 3 cycles after its start drops → sequencer stays in RELEASE for those 3 cycles, then starts slot 1.
- Abort: start drops mid-RUN on slot 1 → next cycle eng_start=0, vga_plot=0, state IDLE, done stays 0. A new start restarts from slot 0.
- Reset mid-run: rst pulse (asynchronous, between clock edges) during RUN → all outputs 0 immediately, state IDLE. After release, a normal run completes.
